// File: rtl/packet_tx_framer_if.sv
// Valid/ready link carrying serialised packet frames toward the radio/MAC.
// The framer drives through master; the link partner uses slave.
interface packet_tx_framer_if #(
   parameter int WORD_WIDTH = 16
);
   logic                  tx_valid;
   logic                  tx_ready;
   logic [WORD_WIDTH-1:0] tx_data;
   logic                  tx_sof;
   logic                  tx_eof;

   modport master (output tx_valid, tx_data, tx_sof, tx_eof, input tx_ready);
   modport slave  (input tx_valid, tx_data, tx_sof, tx_eof, output tx_ready);
endinterface

// File: rtl/packet_tx_framer.sv
// Captures packed reward packets into a whole-packet FIFO and serialises each
// one as an 8-word frame on a valid/ready link, with an optional inter-frame gap.
module packet_tx_framer #(
   parameter int WORD_WIDTH = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic                            clk,
   input  logic                            nrst,
   input  logic                            en,
   input  logic                            push,
   input  logic [2:0]                      rPacketType,
   input  logic [WORD_WIDTH-1:0]           rDestinationID,
   input  logic [WORD_WIDTH-1:0]           rSourceID,
   input  logic [WORD_WIDTH-1:0]           rEnergyLeft,
   input  logic [WORD_WIDTH-1:0]           rQValue,
   input  logic [WORD_WIDTH-1:0]           rSourceHops,
   input  logic [WORD_WIDTH-1:0]           rChosenCH,
   input  logic [WORD_WIDTH-1:0]           rHopsFromCH,
   packet_tx_framer_if.master              tx,
   output logic                            tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
   output logic [7:0]                      drop_invalid_cnt,
   output logic [7:0]                      drop_full_cnt
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = $clog2(GAP_CYCLES + 2);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

   logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH][8];
   logic [WORD_WIDTH-1:0] cap_word [8];

   state_t          state_q, state_d;
   logic [2:0]      beat_q, beat_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      inv_cnt_q, inv_cnt_d;
   logic [7:0]      full_cnt_q, full_cnt_d;
   logic            is_invalid, is_full, push_ok, pop;

   always_comb begin
      cap_word[0] = WORD_WIDTH'(rPacketType);
      cap_word[1] = rDestinationID;
      cap_word[2] = rSourceID;
      cap_word[3] = rEnergyLeft;
      cap_word[4] = rQValue;
      cap_word[5] = rSourceHops;
      cap_word[6] = rChosenCH;
      cap_word[7] = rHopsFromCH;
   end

   // Fullness uses the pre-edge count, so a same-edge pop never frees room.
   assign is_invalid = (rPacketType == 3'b111);
   assign is_full    = (count_q == CW'(FIFO_DEPTH));
   assign push_ok    = push && !is_invalid && !is_full;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         for (int i = 0; i < 8; i++) mem_q[wr_ptr_q][i] <= cap_word[i];
      end
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q + (push_ok ? 1'b1 : 1'b0);
      rd_ptr_d   = rd_ptr_q + (pop ? 1'b1 : 1'b0);
      count_d    = count_q;
      if (push_ok && !pop) count_d = count_q + 1'b1;
      if (!push_ok && pop) count_d = count_q - 1'b1;
      inv_cnt_d  = inv_cnt_q;
      full_cnt_d = full_cnt_q;
      if (push && is_invalid && inv_cnt_q != 8'hFF) inv_cnt_d = inv_cnt_q + 1'b1;
      if (push && !is_invalid && is_full && full_cnt_q != 8'hFF)
         full_cnt_d = full_cnt_q + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      gap_d   = gap_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (en && count_q != '0) begin
               state_d = S_SEND;
               beat_d  = 3'd0;
            end
         end
         S_SEND: begin
            if (tx.tx_ready) begin
               if (beat_q == 3'd7) begin
                  pop    = 1'b1;
                  beat_d = 3'd0;
                  if (GAP_CYCLES > 0) begin
                     state_d = S_GAP;
                     gap_d   = GW'(GAP_CYCLES);
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  beat_d = beat_q + 3'd1;
               end
            end
         end
         S_GAP: begin
            gap_d = gap_q - 1'b1;
            if (gap_q <= GW'(1)) begin
               gap_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= S_IDLE;
         beat_q     <= '0;
         gap_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         inv_cnt_q  <= '0;
         full_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         gap_q      <= gap_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         inv_cnt_q  <= inv_cnt_d;
         full_cnt_q <= full_cnt_d;
      end
   end

   // Head packet is read straight from storage; outputs are zero off-frame.
   assign tx.tx_valid      = (state_q == S_SEND);
   assign tx.tx_data       = tx.tx_valid ? mem_q[rd_ptr_q][beat_q] : '0;
   assign tx.tx_sof        = tx.tx_valid && (beat_q == 3'd0);
   assign tx.tx_eof        = tx.tx_valid && (beat_q == 3'd7);
   assign tx_busy          = (state_q != S_IDLE);
   assign fifo_count       = count_q;
   assign drop_invalid_cnt = inv_cnt_q;
   assign drop_full_cnt    = full_cnt_q;
endmodule

// File: tb/tb_packet_tx_framer.sv
// Directed + randomized bench for packet_tx_framer; a packet-queue model
// predicts the beat stream, occupancy and drop counters.
module tb_packet_tx_framer;
   localparam int DEPTH = 4;

   typedef logic [15:0] pkt_t [8];

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        en = 1'b0;
   logic        push = 1'b0;
   logic [2:0]  ptype = 3'd0;
   logic [15:0] fld [8];
   logic        tx_busy;
   logic [2:0]  fifo_count;
   logic [7:0]  drop_invalid_cnt, drop_full_cnt;

   packet_tx_framer_if #(.WORD_WIDTH(16)) tx_if ();

   packet_tx_framer #(.WORD_WIDTH(16), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(2)) dut (
      .clk(clk), .nrst(nrst), .en(en), .push(push), .rPacketType(ptype),
      .rDestinationID(fld[1]), .rSourceID(fld[2]), .rEnergyLeft(fld[3]),
      .rQValue(fld[4]), .rSourceHops(fld[5]), .rChosenCH(fld[6]),
      .rHopsFromCH(fld[7]), .tx(tx_if.master), .tx_busy(tx_busy),
      .fifo_count(fifo_count), .drop_invalid_cnt(drop_invalid_cnt),
      .drop_full_cnt(drop_full_cnt)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   failures = 0;
   pkt_t q [$];
   int   beat_m = 0;
   bit   pend_pop = 0;
   int   exp_inv = 0;
   int   exp_full = 0;
   logic obs_valid, obs_sof, obs_eof, obs_busy;
   int   obs_beat;
   int   full_before;
   bit   hit, seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic pkt_t cur_pkt();
      pkt_t p;
      p[0] = {13'b0, ptype};
      for (int i = 1; i < 8; i++) p[i] = fld[i];
      return p;
   endfunction

   task automatic rnd_fields(input bit valid_type);
      ptype = valid_type ? 3'($urandom_range(0, 6)) : 3'b111;
      for (int i = 1; i < 8; i++) fld[i] = 16'($urandom);
   endtask

   // Negedge: compare outputs against the head of the model queue.
   task automatic sample();
      @(negedge clk);
      obs_valid = tx_if.tx_valid;
      obs_sof   = tx_if.tx_sof;
      obs_eof   = tx_if.tx_eof;
      obs_busy  = tx_busy;
      obs_beat  = beat_m;
      pend_pop  = 0;
      chk("fifo_count", fifo_count, q.size());
      chk("drop_invalid", drop_invalid_cnt, exp_inv);
      chk("drop_full", drop_full_cnt, exp_full);
      if (obs_valid) begin
         chk("valid_with_data", (q.size() != 0), 1);
         if (q.size() != 0) begin
            chk("beat_data", tx_if.tx_data, q[0][beat_m]);
            chk("beat_sof", obs_sof, (beat_m == 0));
            chk("beat_eof", obs_eof, (beat_m == 7));
            if (tx_if.tx_ready) begin
               if (beat_m == 7) pend_pop = 1;
               else beat_m++;
            end
         end
      end else begin
         chk("idle_data", tx_if.tx_data, 0);
         chk("idle_sof", obs_sof, 0);
         chk("idle_eof", obs_eof, 0);
      end
   endtask

   // Posedge: capture (judged on pre-edge occupancy) then pop.
   task automatic edge_step();
      @(posedge clk);
      if (push) begin
         if (ptype == 3'b111) begin
            if (exp_inv < 255) exp_inv++;
         end else if (q.size() == DEPTH) begin
            if (exp_full < 255) exp_full++;
         end else begin
            q.push_back(cur_pkt());
         end
      end
      if (pend_pop) begin
         void'(q.pop_front());
         beat_m = 0;
      end
      #1;
   endtask

   task automatic tick();
      sample();
      edge_step();
   endtask

   task automatic drain(input int max_cyc);
      en = 1'b1;
      tx_if.tx_ready = 1'b1;
      for (int i = 0; i < max_cyc && q.size() != 0; i++) tick();
      tick();
      chk("drain_count", fifo_count, 0);
   endtask

   task automatic push_one(input bit valid_type);
      rnd_fields(valid_type);
      push = 1'b1;
      tick();
      push = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) fld[i] = '0;
      tx_if.tx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", tx_if.tx_valid, 0);
      chk("rst_data", tx_if.tx_data, 0);
      chk("rst_sof", tx_if.tx_sof, 0);
      chk("rst_eof", tx_if.tx_eof, 0);
      chk("rst_busy", tx_busy, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_dinv", drop_invalid_cnt, 0);
      chk("rst_dfull", drop_full_cnt, 0);
      nrst = 1'b1;
      tick();

      // Single packet: latency, word order, gap length.
      en = 1'b1;
      ptype = 3'b000;
      for (int i = 1; i < 8; i++) fld[i] = 16'(i);
      push = 1'b1;
      tick();
      push = 1'b0;
      tick();
      chk("lat_c1_valid", obs_valid, 0);
      tick();
      chk("lat_c2_valid", obs_valid, 1);
      chk("lat_c2_sof", obs_sof, 1);
      for (int i = 1; i < 8; i++) begin
         tick();
         chk("single_valid", obs_valid, 1);
      end
      chk("single_eof", obs_eof, 1);
      tick();
      chk("gap1_valid", obs_valid, 0);
      chk("gap1_busy", obs_busy, 1);
      chk("cnt_after_eof", fifo_count, 0);
      tick();
      chk("gap2_busy", obs_busy, 1);
      tick();
      chk("gap_end_busy", obs_busy, 0);

      // Backpressure with a fixed 1,0,0,1 ready pattern.
      push_one(1);
      for (int i = 0; i < 80 && q.size() != 0; i++) begin
         tx_if.tx_ready = (i % 4 == 0) || (i % 4 == 3);
         tick();
      end
      drain(20);

      // Overflow while disabled, then ordered drain with pointer wrap.
      en = 1'b0;
      for (int i = 0; i < 5; i++) push_one(1);
      tick();
      chk("ovf_count", fifo_count, 4);
      chk("ovf_dfull", drop_full_cnt, 1);
      drain(120);

      // Invalid types: single, then saturation.
      push_one(0);
      tick();
      chk("inv_one", drop_invalid_cnt, 1);
      chk("inv_count", fifo_count, 0);
      chk("inv_no_frame", obs_valid, 0);
      rnd_fields(0);
      push = 1'b1;
      for (int i = 0; i < 299; i++) tick();
      push = 1'b0;
      tick();
      chk("inv_sat", drop_invalid_cnt, 255);

      // Push on the eof edge with a full FIFO, then with two queued.
      for (int pass = 0; pass < 2; pass++) begin
         en = 1'b0;
         for (int i = 0; i < (pass == 0 ? 4 : 2); i++) push_one(1);
         full_before = exp_full;
         en = 1'b1;
         tx_if.tx_ready = 1'b1;
         hit = 0;
         for (int i = 0; i < 40 && !hit; i++) begin
            sample();
            if (obs_eof) begin
               rnd_fields(1);
               push = 1'b1;
               hit = 1;
            end
            edge_step();
            push = 1'b0;
         end
         chk("pp_eof_seen", hit, 1);
         tick();
         chk(pass == 0 ? "pp4_count" : "pp2_count", fifo_count, (pass == 0) ? 3 : 2);
         chk("pp_dfull", drop_full_cnt, full_before + ((pass == 0) ? 1 : 0));
         drain(150);
      end

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         en = ($urandom_range(0, 3) != 0);
         tx_if.tx_ready = ($urandom_range(0, 2) != 0);
         push = ($urandom_range(0, 2) == 0);
         rnd_fields($urandom_range(0, 5) != 0);
         tick();
      end
      push = 1'b0;
      drain(200);

      // Reset in the middle of a frame at beat 3.
      en = 1'b1;
      tx_if.tx_ready = 1'b1;
      push_one(1);
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         sample();
         if (obs_valid && obs_beat == 3) hit = 1;
         else edge_step();
      end
      chk("mid_beat3_seen", hit, 1);
      nrst = 1'b0;
      #1;
      chk("mid_rst_valid", tx_if.tx_valid, 0);
      chk("mid_rst_data", tx_if.tx_data, 0);
      chk("mid_rst_sof", tx_if.tx_sof, 0);
      chk("mid_rst_eof", tx_if.tx_eof, 0);
      chk("mid_rst_busy", tx_busy, 0);
      chk("mid_rst_count", fifo_count, 0);
      q.delete();
      beat_m = 0;
      pend_pop = 0;
      exp_inv = 0;
      exp_full = 0;
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (obs_valid) seen = 1;
      end
      chk("no_residual_frame", seen, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
